activation_writeback: RTL and testbench
=======================================

// Module: activation_writeback
// PURPOSE
// - Write-back stage after the 4-lane activation unit: accepts one row of 4 activated
//   values per handshake, buffers rows, and serialises them to the byte-wide output memory.
// - Sits between the activation outputs (out1..out4) and the result SRAM write port.
// - Each transfer is a job of num_rows rows, written to consecutive addresses from base_addr.
// PARAMETERS
// - bit_width   8  width of each activated lane value and of mem_wdata
// - addr_width  8  output memory address width
// - fifo_depth  4  row buffer depth in rows; must be a power of two, >= 2
// PORTS
// - clk        in   1           single clock, rising edge
// - rst        in   1           synchronous, active-high reset
// - start      in   1           one-cycle job start pulse; sampled only in IDLE
// - base_addr  in   addr_width  first write address, latched on start
// - num_rows   in   addr_width  rows in this job, latched on start
// - in_valid   in   1           row on in1..in4 is valid
// - in_ready   out  1           block accepts a row this cycle
// - in1..in4   in   bit_width   activated lane values; in1 is the lowest address
// - mem_we     out  1           output memory write strobe
// - mem_addr   out  addr_width  write address
// - mem_wdata  out  bit_width   write data
// - busy       out  1           high from the cycle after start until done
// - done       out  1           one-cycle pulse when the last byte has been written
// BEHAVIOUR
// - Reset: state=IDLE, FIFO empty, all counters 0; in_ready=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, busy=0, done=0. Reset mid-job aborts the job; no further writes.
// - FSM states: IDLE, RUN, DONE.
//   IDLE -start-> RUN (latch base_addr and num_rows; clear rows_in, rows_out, lane_idx).
//   If num_rows==0 at start: IDLE -> DONE directly, with no writes.
//   RUN -> DONE in the cycle after the final byte write (rows_out==num_rows). DONE -> IDLE after 1 cycle.
// - done=1 only in DONE. busy=1 in RUN and DONE. start outside IDLE is ignored.
// - Input handshake: in_ready = (state==RUN) && !fifo_full && (rows_in < num_rows).
//   A row is accepted when in_valid && in_ready; all 4 lanes are pushed as one FIFO entry.
//   in_ready does not depend on in_valid. A row offered after the job is complete is not accepted.
// - Full FIFO: in_ready=0, even if a pop occurs in the same cycle.
//   A simultaneous push and pop on a non-full FIFO are both performed.
// - Serialiser: when the FIFO is non-empty in RUN, it emits one byte per cycle from the head entry
//   in lane order in1, in2, in3, in4 (lane_idx 0..3).
//   mem_we, mem_addr and mem_wdata are registered outputs.
//   The head entry is popped in the cycle its lane 4 is issued; rows_out increments at that point.
//   If the FIFO is empty, mem_we=0 (bubble); lane_idx holds.
// - Latency: a row accepted at clock edge t produces lane 1 with mem_we=1 during cycle t+1,
//   and lane 4 during cycle t+4. Sustained throughput is 1 row per 4 cycles.
//   in_ready deasserts when the FIFO fills.
// - Address: mem_addr = base_addr + 4*row + lane, computed mod 2^addr_width
//   (wrap-around permitted and silent).
//   Row counters are addr_width+1 bits wide, so num_rows = 2^addr_width-1 does not overflow.
// - No data transformation: mem_wdata equals the accepted lane value bit-for-bit.
// STRUCTURE
// - tpu_pkg holds: typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DONE} wb_state_t;
//   localparam LANES = 4; typedef logic [LANES*bit_width-1:0] row_t (packed in4..in1, in1 in LSBs).
// - Sub-module sync_fifo: width LANES*bit_width, depth fifo_depth.
//   Ports: push, pop, wdata, rdata, full, empty. Show-ahead read. Pointers carry an extra wrap bit.
// - The top level contains the FSM, counters, lane mux and output registers.
// TESTING
// - Single row: base=0x10, rows=1, row {0x0A,0x0B,0x0C,0xFF} ->
//   writes 0x10:0x0A, 0x11:0x0B, 0x12:0x0C, 0x13:0xFF on 4 consecutive cycles; done 1 cycle later.
// - Backpressure: rows=8, in_valid held high, lane values = row index ->
//   in_ready low while the FIFO holds 4 rows; 32 ordered writes; no drops or duplicates.
// - Bubbles: rows=3, with 10 idle cycles between rows -> mem_we=0 during gaps, addresses contiguous.
// - Wrap: base=0xFE, rows=1, row {1,2,3,4} -> addresses 0xFE, 0xFF, 0x00, 0x01.
// - Zero/ignored: rows=0 -> done 1 cycle after start, no mem_we. start pulsed in RUN -> no effect.
// - Reset mid-job after 5 writes: all outputs at reset values next cycle;
//   a new job then starts cleanly from its own base_addr.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the activation write-back path.
// Row entries pack lanes in4..in1 with in1 in the LSBs.
package tpu_pkg;

    typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DONE} wb_state_t;

    localparam int LANES = 4;
    localparam int BIT_WIDTH = 8;

    typedef logic [LANES*BIT_WIDTH-1:0] row_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit
// so full and empty are distinguished without a counter.
module sync_fifo #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int aw = $clog2(depth);

    logic [aw:0]      wptr;
    logic [aw:0]      rptr;
    logic [width-1:0] mem [depth];

    assign empty = (wptr == rptr);
    assign full  = (wptr[aw] != rptr[aw]) &&
                   (wptr[aw-1:0] == rptr[aw-1:0]);
    assign rdata = mem[rptr[aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[aw-1:0]] <= wdata;
    end

endmodule

// File: rtl/activation_writeback.sv
// Buffers 4-lane activation rows and serialises them, one byte
// per cycle, to consecutive addresses of the result SRAM.
module activation_writeback
    import tpu_pkg::*;
#(
    parameter int bit_width  = 8,
    parameter int addr_width = 8,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width-1:0] num_rows,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [bit_width-1:0]  in1,
    input  logic [bit_width-1:0]  in2,
    input  logic [bit_width-1:0]  in3,
    input  logic [bit_width-1:0]  in4,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [bit_width-1:0]  mem_wdata,
    output logic                  busy,
    output logic                  done
);

    logic [LANES*bit_width-1:0] row;
    logic [LANES*bit_width-1:0] head;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;

    wb_state_t             state;
    logic [addr_width-1:0] base;
    logic [addr_width:0]   rows;
    logic [addr_width:0]   rows_in;
    logic [addr_width:0]   rows_out;
    logic [1:0]            lane_idx;
    logic [addr_width-1:0] row_off;
    logic [addr_width-1:0] addr_next;

    assign row = {in4, in3, in2, in1};

    // A full FIFO refuses a row even when the head pops this cycle.
    assign in_ready = (state == WB_RUN) && !full && (rows_in < rows);
    assign push     = in_valid && in_ready;
    assign pop      = (state == WB_RUN) && !empty && (lane_idx == 2'd3);

    // Address arithmetic wraps silently modulo 2^addr_width.
    assign row_off   = rows_out[addr_width-1:0] << 2;
    assign addr_next = base + row_off + addr_width'(lane_idx);

    sync_fifo #(
        .width (LANES*bit_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (row),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WB_IDLE;
            base      <= '0;
            rows      <= '0;
            rows_in   <= '0;
            rows_out  <= '0;
            lane_idx  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (push)
                rows_in <= rows_in + 1'b1;
            unique case (state)
                WB_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        base     <= base_addr;
                        rows     <= {1'b0, num_rows};
                        rows_in  <= '0;
                        rows_out <= '0;
                        lane_idx <= '0;
                        busy     <= 1'b1;
                        if (num_rows == '0) begin
                            state <= WB_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WB_RUN;
                        end
                    end
                end
                WB_RUN: begin
                    if (!empty) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_next;
                        mem_wdata <= head[lane_idx*bit_width +: bit_width];
                        lane_idx  <= lane_idx + 2'd1;
                        if (lane_idx == 2'd3)
                            rows_out <= rows_out + 1'b1;
                    end else if (rows_out == rows) begin
                        state <= WB_DONE;
                        done  <= 1'b1;
                    end
                end
                WB_DONE: begin
                    state <= WB_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activation_writeback.sv
// Directed bench for activation_writeback: single row, backpressure,
// bubbles, wrap, zero rows, ignored start and mid-job reset.
module tb_activation_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] num_rows;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in1, in2, in3, in4;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  done_cyc;
    bit  done_seen;
    int  acc_cyc;
    int  start_cyc;
    int  stalls;
    int  vectors = 0;
    int  miscompares = 0;

    activation_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we)
            wq.push_back('{cyc, mem_addr, mem_wdata});
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [7:0] b, input logic [7:0] n);
        wq.delete();
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        num_rows  = n;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic send_row(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        int n = 0;
        in1 = a; in2 = b; in3 = c; in4 = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            if (!in_ready) stalls++;
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", done_seen, 1);
    endtask

    task automatic check_wr(input int i, input logic [7:0] a,
                            input logic [7:0] d);
        if (i < wq.size()) begin
            check($sformatf("addr[%0d]", i), wq[i].addr, a);
            check($sformatf("data[%0d]", i), wq[i].data, d);
        end else begin
            check($sformatf("missing[%0d]", i), 0, 1);
        end
    endtask

    initial begin
        logic [7:0] d1[4];
        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
        in_valid = 1'b0; in1 = '0; in2 = '0; in3 = '0; in4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single row with exact latency
        start_job(8'h10, 8'd1);
        check("t1_busy", busy, 1);
        send_row(8'h0A, 8'h0B, 8'h0C, 8'hFF);
        wait_done();
        d1 = '{8'h0A, 8'h0B, 8'h0C, 8'hFF};
        check("t1_count", wq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_wr(i, 8'h10 + 8'(i), d1[i]);
            if (i < wq.size())
                check($sformatf("t1_cyc[%0d]", i), wq[i].cyc, acc_cyc + 1 + i);
        end
        check("t1_done_cyc", done_cyc, acc_cyc + 5);

        // backpressure: in_valid held, 8 rows
        stalls = 0;
        start_job(8'h40, 8'd8);
        for (int r = 0; r < 8; r++)
            send_row(8'(r), 8'(r), 8'(r), 8'(r));
        in_valid = 1'b1;
        @(negedge clk);
        check("t2_ready_after_last", in_ready, 0);
        in_valid = 1'b0;
        check("t2_stalled", stalls > 0, 1);
        wait_done();
        check("t2_count", wq.size(), 32);
        for (int i = 0; i < 32; i++)
            check_wr(i, 8'h40 + 8'(i), 8'(i / 4));

        // bubbles between rows
        start_job(8'h80, 8'd3);
        for (int r = 0; r < 3; r++) begin
            send_row(8'(8'h30 + 4*r), 8'(8'h31 + 4*r),
                     8'(8'h32 + 4*r), 8'(8'h33 + 4*r));
            repeat (10) @(posedge clk);
            #1;
        end
        wait_done();
        check("t3_count", wq.size(), 12);
        for (int i = 0; i < 12; i++)
            check_wr(i, 8'h80 + 8'(i), 8'h30 + 8'(i));
        if (wq.size() == 12) begin
            check("t3_gap1", wq[4].cyc - wq[3].cyc > 1, 1);
            check("t3_gap2", wq[8].cyc - wq[7].cyc > 1, 1);
        end

        // address wrap
        start_job(8'hFE, 8'd1);
        send_row(8'd1, 8'd2, 8'd3, 8'd4);
        wait_done();
        check("t4_count", wq.size(), 4);
        check_wr(0, 8'hFE, 8'd1);
        check_wr(1, 8'hFF, 8'd2);
        check_wr(2, 8'h00, 8'd3);
        check_wr(3, 8'h01, 8'd4);

        // zero rows
        start_job(8'h33, 8'd0);
        wait_done();
        check("t5_done_cyc", done_cyc, start_cyc);
        check("t5_count", wq.size(), 0);

        // start during RUN is ignored
        start_job(8'h20, 8'd1);
        start = 1'b1; base_addr = 8'h99; num_rows = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        send_row(8'h5A, 8'h5B, 8'h5C, 8'h5D);
        wait_done();
        check("t6_count", wq.size(), 4);
        check_wr(0, 8'h20, 8'h5A);
        check_wr(3, 8'h23, 8'h5D);
        @(negedge clk);
        @(negedge clk);
        check("t6_idle_busy", busy, 0);

        // reset mid-job, then a fresh job
        start_job(8'h50, 8'd3);
        for (int r = 0; r < 3; r++)
            send_row(8'(r), 8'(r), 8'(r), 8'(r));
        for (int n = 0; n < 100 && wq.size() < 5; n++)
            @(negedge clk);
        check("t7_five_writes", wq.size() >= 5, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t7_rst_mem_we", mem_we, 0);
        check("t7_rst_addr", mem_addr, 0);
        check("t7_rst_wdata", mem_wdata, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_done", done, 0);
        check("t7_rst_ready", in_ready, 0);
        rst = 1'b0;
        wq.delete();
        repeat (6) @(negedge clk);
        check("t7_no_writes", wq.size(), 0);
        start_job(8'h60, 8'd1);
        send_row(8'h11, 8'h22, 8'h33, 8'h44);
        wait_done();
        check("t7_new_count", wq.size(), 4);
        check_wr(0, 8'h60, 8'h11);
        check_wr(1, 8'h61, 8'h22);
        check_wr(2, 8'h62, 8'h33);
        check_wr(3, 8'h63, 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
